mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the instruction-fetch path and the data-memory path of the pipelined core. Accepts one outstanding instruction read and one outstanding data read/write, grants exactly one to the shared RAM port at a time, and returns completion through per-requester wait signals. Data requests win by default; a starvation counter guarantees instruction fetch progress.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction read is pending (1-15).
- MAX_RETRY, 3: RAM ERROR responses tolerated per transaction before it is abandoned (0-7).
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  synchronous active-low reset, sampled on rising CLK.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction word address.
- iload  out  32  instruction read data; valid only when iREN && !iwait.
- iwait  out  1  1 = instruction request not complete.
- dREN  in  1  data read request.
- dWEN  in  1  data write request (dREN && dWEN is illegal; treated as write).
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dload  out  32  data read data; valid only when dREN && !dwait.
- dwait  out  1  1 = data request not complete.
- ramREN, ramWEN  out  1 each  RAM enables.
- ramaddr, ramstore  out  32 each  RAM address / write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE / BUSY / ACCESS / ERROR (ramstate_t).
- err  out  1  sticky: a transaction was abandoned after MAX_RETRY errors; cleared only by reset.

## Operation
- States: IDLE, IGRANT, DGRANT.
- IDLE: ram enables low. Arbitration if any request: data (dREN|dWEN) wins unless iREN && starve_cnt == STARVE_LIMIT, then instruction. Go to chosen grant state next cycle.
- IGRANT: ramREN=1, ramaddr=iaddr. DGRANT: ramREN=dREN&&!dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore. Address/data driven combinationally from held requester inputs.
- In grant state, ramstate==ACCESS: granted wait driven low that cycle, iload/dload = ramload (combinational pass-through); next state IDLE.
- ramstate==ERROR: retry_cnt++ and remain; if retry_cnt == MAX_RETRY, set err, drop granted wait low (data undefined), go to IDLE.
- FREE/BUSY: remain, wait high.
- Granted requester drops its request before ACCESS: abort, enables low next cycle, state IDLE, no completion, counters unchanged except retry_cnt cleared.
- Non-granted wait always high while its request is asserted; wait outputs are 1 whenever the corresponding request is low.
- starve_cnt (4 bit): on each data completion with iREN asserted, increment (saturate at STARVE_LIMIT); cleared on any instruction completion or when iREN low at a data completion.
- retry_cnt (3 bit): cleared on entry to any grant state.

## Timing
- Reset values: state IDLE, starve_cnt 0, retry_cnt 0, err 0, ramREN/ramWEN 0, ramaddr/ramstore 0, iwait/dwait 1, iload/dload 0.
- Minimum latency: request seen in IDLE at cycle 0 -> grant cycle 1 -> earliest completion (wait low) cycle 1 if RAM returns ACCESS immediately; IDLE cycle 2. One mandatory IDLE cycle between transactions.
- Wait deasserts for exactly one cycle per completion; requester must change or drop the request by the following edge.
- Simultaneous iREN and dREN in IDLE, starve_cnt < STARVE_LIMIT: data granted.
- Reset asserted mid-transaction: next edge returns to IDLE with enables low; RAM transaction discarded.

## Structure
- ramstate_t and word_t come from cpu_types_pkg; add arb_state_t (IDLE, IGRANT, DGRANT) to cpu_types_pkg.
- No sub-module; single FSM plus two counters. Instantiated between the cache interfaces and the RAM, replacing direct datapath-to-RAM wiring.

## Test plan
- iREN only, iaddr=0x40, RAM ACCESS after 2 BUSY cycles -> ramREN=1, ramaddr=0x40 cycles 1-3; iwait low cycle 3 with iload=ramload; IDLE cycle 4.
- iREN and dWEN together, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first, ramWEN=1, ramstore=0xDEADBEEF; then IGRANT after one IDLE cycle.
- iREN held, dREN reasserted continuously, STARVE_LIMIT=4 -> exactly 4 data completions, then an instruction grant, then starve_cnt=0.
- dREN, RAM returns ERROR 3 times then ACCESS with MAX_RETRY=3 -> abandoned on third ERROR, err=1, dwait low one cycle; err stays 1 until nRST low.
- dREN dropped during BUSY -> ramREN low next cycle, state IDLE, no dwait pulse.
- nRST low during DGRANT -> all outputs at reset values after next edge, err=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM word, RAM handshake state and memory arbiter FSM state.
// No ports; imported by the arbiter, its interface and the bench.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE,
      BUSY,
      ACCESS,
      ERROR
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE,
      IGRANT,
      DGRANT
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the RAM.
// Ports: slave = arbiter view, master = requester/RAM side view.
interface mem_arbiter_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   word_t     iload;
   logic      iwait;

   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   word_t     dload;
   logic      dwait;

   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   logic      err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore,
      input  ramload, ramstate,
      output iload, iwait, dload, dwait,
      output ramREN, ramWEN, ramaddr, ramstore, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore,
      output ramload, ramstate,
      input  iload, iwait, dload, dwait,
      input  ramREN, ramWEN, ramaddr, ramstore, err
   );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data wins, starvation counter forces fetch progress.
// Ports: CLK, nRST (sync, active low), bus (mem_arbiter_if.slave).
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_RETRY    = 3
) (
   input  logic         CLK,
   input  logic         nRST,
   mem_arbiter_if.slave bus
);

   localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);
   localparam logic [3:0] RLIM = 4'(MAX_RETRY);

   arb_state_t state;
   arb_state_t next_state;
   logic [3:0] starve_cnt;
   logic [2:0] retry_cnt;
   logic       err_q;

   logic dreq;
   logic starved;
   logic last_try;
   logic ram_ok;
   logic ram_err;
   logic i_done;
   logic d_done;
   logic retry_inc;
   logic abandon;

   assign dreq    = bus.dREN | bus.dWEN;
   assign starved = bus.iREN && (starve_cnt == SLIM);
   assign ram_ok  = (bus.ramstate == ACCESS);
   assign ram_err = (bus.ramstate == ERROR);
   assign bus.err = err_q;

   // The current ERROR is the one that exhausts the retry budget.
   assign last_try = ({1'b0, retry_cnt} + 4'd1) >= RLIM;

   always_comb begin
      next_state   = state;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      bus.iload    = '0;
      bus.dload    = '0;
      i_done       = 1'b0;
      d_done       = 1'b0;
      retry_inc    = 1'b0;
      abandon      = 1'b0;
      unique case (state)
         IDLE: begin
            if (dreq && !starved)
               next_state = DGRANT;
            else if (bus.iREN)
               next_state = IGRANT;
         end
         IGRANT: begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr;
            if (!bus.iREN) begin
               next_state = IDLE;
            end else begin
               unique case (1'b1)
                  ram_ok: begin
                     bus.iwait  = 1'b0;
                     bus.iload  = bus.ramload;
                     i_done     = 1'b1;
                     next_state = IDLE;
                  end
                  ram_err: begin
                     if (last_try) begin
                        bus.iwait  = 1'b0;
                        abandon    = 1'b1;
                        i_done     = 1'b1;
                        next_state = IDLE;
                     end else begin
                        retry_inc = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         DGRANT: begin
            // A write wins over a simultaneous read.
            bus.ramREN   = bus.dREN & ~bus.dWEN;
            bus.ramWEN   = bus.dWEN;
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            if (!dreq) begin
               next_state = IDLE;
            end else begin
               unique case (1'b1)
                  ram_ok: begin
                     bus.dwait  = 1'b0;
                     bus.dload  = bus.ramload;
                     d_done     = 1'b1;
                     next_state = IDLE;
                  end
                  ram_err: begin
                     if (last_try) begin
                        bus.dwait  = 1'b0;
                        abandon    = 1'b1;
                        d_done     = 1'b1;
                        next_state = IDLE;
                     end else begin
                        retry_inc = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state      <= IDLE;
         starve_cnt <= '0;
         retry_cnt  <= '0;
         err_q      <= 1'b0;
      end else begin
         state <= next_state;
         // Any state change (grant entry, completion, abort) restarts retries.
         if (next_state != state)
            retry_cnt <= '0;
         else if (retry_inc)
            retry_cnt <= retry_cnt + 3'd1;
         if (abandon)
            err_q <= 1'b1;
         if (d_done) begin
            if (!bus.iREN)
               starve_cnt <= '0;
            else if (starve_cnt < SLIM)
               starve_cnt <= starve_cnt + 4'd1;
         end else if (i_done) begin
            starve_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a scripted RAM latency/error model.
// Ports: none (top-level bench).
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam word_t KEY = 32'h5A5A_0000;

   typedef struct {
      logic  wr;
      logic  chkd;
      word_t val;
   } exp_t;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   mem_arbiter_if bus();

   mem_arbiter #(
      .STARVE_LIMIT(4),
      .MAX_RETRY(3)
   ) dut (
      .CLK(CLK),
      .nRST(nRST),
      .bus(bus)
   );

   int    total = 0;
   int    bad   = 0;
   int    busy_n = 0;
   int    err_n  = 0;
   word_t iq[$];
   exp_t  dq[$];
   logic  i_fire = 1'b0;
   logic  d_fire = 1'b0;

   function automatic exp_t mk(logic wr, logic chkd, word_t val);
      exp_t e;
      e.wr   = wr;
      e.chkd = chkd;
      e.val  = val;
      return e;
   endfunction

   task automatic chk(input string tag, input word_t got, input word_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // RAM: busy_n BUSY cycles, then err_n ERROR cycles, then ACCESS.
   initial begin
      int k;
      k = 0;
      bus.ramstate = FREE;
      bus.ramload  = '0;
      forever begin
         @(posedge CLK);
         #1;
         if (bus.ramREN || bus.ramWEN) begin
            bus.ramstate = (k < busy_n) ? BUSY :
                           ((k < busy_n + err_n) ? ERROR : ACCESS);
            k++;
         end else begin
            bus.ramstate = FREE;
            k = 0;
         end
         bus.ramload = bus.ramaddr ^ KEY;
      end
   end

   // Sample one cycle at its falling edge and retire completions.
   task automatic cyc();
      exp_t  e;
      word_t ei;
      @(negedge CLK);
      i_fire = bus.iREN && !bus.iwait;
      d_fire = (bus.dREN || bus.dWEN) && !bus.dwait;
      if (i_fire) begin
         chk("i_expected", 32'(iq.size() > 0), 32'd1);
         if (iq.size() > 0) begin
            ei = iq.pop_front();
            chk("iload", bus.iload, ei);
         end
      end
      if (d_fire) begin
         chk("d_expected", 32'(dq.size() > 0), 32'd1);
         if (dq.size() > 0) begin
            e = dq.pop_front();
            if (e.chkd && e.wr)
               chk("ramstore", bus.ramstore, e.val);
            else if (e.chkd)
               chk("dload", bus.dload, e.val);
         end
      end
   endtask

   // Step just past the next rising edge to change held requests.
   task automatic adv();
      @(posedge CLK);
      #2;
   endtask

   task automatic wait_fire(input bit want_i, input int lim, input string tag);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < lim && !seen; n++) begin
         cyc();
         seen = want_i ? i_fire : d_fire;
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic check_reset(input string p);
      chk({p, "_ren"}, 32'(bus.ramREN), 32'd0);
      chk({p, "_wen"}, 32'(bus.ramWEN), 32'd0);
      chk({p, "_addr"}, bus.ramaddr, 32'd0);
      chk({p, "_store"}, bus.ramstore, 32'd0);
      chk({p, "_iwait"}, 32'(bus.iwait), 32'd1);
      chk({p, "_dwait"}, 32'(bus.dwait), 32'd1);
      chk({p, "_iload"}, bus.iload, 32'd0);
      chk({p, "_dload"}, bus.dload, 32'd0);
      chk({p, "_err"}, 32'(bus.err), 32'd0);
   endtask

   initial begin
      int dcnt;
      bit got_i;
      nRST       = 1'b0;
      bus.iREN   = 1'b0;
      bus.iaddr  = '0;
      bus.dREN   = 1'b0;
      bus.dWEN   = 1'b0;
      bus.daddr  = '0;
      bus.dstore = '0;
      cyc();
      cyc();
      check_reset("rst");
      nRST = 1'b1;
      cyc();

      // Instruction read with two BUSY cycles.
      busy_n = 2;
      err_n  = 0;
      bus.iREN  = 1'b1;
      bus.iaddr = 32'h40;
      iq.push_back(32'h40 ^ KEY);
      for (int c = 1; c <= 3; c++) begin
         cyc();
         chk("t1_ren", 32'(bus.ramREN), 32'd1);
         chk("t1_addr", bus.ramaddr, 32'h40);
         chk("t1_iwait", 32'(bus.iwait), (c == 3) ? 32'd0 : 32'd1);
      end
      adv();
      bus.iREN = 1'b0;
      cyc();
      chk("t1_idle", 32'(bus.ramREN), 32'd0);

      // Simultaneous fetch and write: write first, gap, then fetch.
      busy_n = 0;
      bus.iREN   = 1'b1;
      bus.iaddr  = 32'h80;
      iq.push_back(32'h80 ^ KEY);
      bus.dWEN   = 1'b1;
      bus.daddr  = 32'h100;
      bus.dstore = 32'hDEAD_BEEF;
      dq.push_back(mk(1'b1, 1'b1, 32'hDEAD_BEEF));
      cyc();
      chk("t2_wen", 32'(bus.ramWEN), 32'd1);
      chk("t2_daddr", bus.ramaddr, 32'h100);
      chk("t2_dfire", 32'(d_fire), 32'd1);
      chk("t2_iwait", 32'(bus.iwait), 32'd1);
      adv();
      bus.dWEN = 1'b0;
      cyc();
      chk("t2_gap", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
      cyc();
      chk("t2_iaddr", bus.ramaddr, 32'h80);
      chk("t2_ifire", 32'(i_fire), 32'd1);
      adv();
      bus.iREN = 1'b0;
      cyc();

      // Starvation: four data completions, then the fetch.
      dcnt  = 0;
      got_i = 1'b0;
      bus.iREN  = 1'b1;
      bus.iaddr = 32'h200;
      iq.push_back(32'h200 ^ KEY);
      bus.dREN  = 1'b1;
      bus.daddr = 32'h300;
      dq.push_back(mk(1'b0, 1'b1, 32'h300 ^ KEY));
      for (int n = 0; n < 60 && !got_i; n++) begin
         cyc();
         if (i_fire) begin
            got_i = 1'b1;
            adv();
            bus.iREN = 1'b0;
         end else if (d_fire) begin
            dcnt++;
            adv();
            bus.daddr = bus.daddr + 32'd4;
            dq.push_back(mk(1'b0, 1'b1, bus.daddr ^ KEY));
         end
      end
      chk("t3_igrant", 32'(got_i), 32'd1);
      chk("t3_dcnt", 32'(dcnt), 32'd4);
      cyc();
      chk("t3_starve", 32'(dut.starve_cnt), 32'd0);
      wait_fire(1'b0, 10, "t3_dtail");
      adv();
      bus.dREN = 1'b0;
      cyc();

      // Three ERRORs abandon the read and set err.
      err_n = 3;
      bus.dREN  = 1'b1;
      bus.daddr = 32'h500;
      dq.push_back(mk(1'b0, 1'b0, '0));
      cyc();
      chk("t4_dwait1", 32'(bus.dwait), 32'd1);
      cyc();
      chk("t4_dwait2", 32'(bus.dwait), 32'd1);
      chk("t4_err_pre", 32'(bus.err), 32'd0);
      cyc();
      chk("t4_dwait3", 32'(bus.dwait), 32'd0);
      adv();
      bus.dREN = 1'b0;
      err_n = 0;
      cyc();
      chk("t4_err", 32'(bus.err), 32'd1);
      chk("t4_idle", 32'(bus.ramREN), 32'd0);
      cyc();
      cyc();
      chk("t4_err_hold", 32'(bus.err), 32'd1);

      // Data read dropped while RAM is busy.
      busy_n = 5;
      bus.dREN  = 1'b1;
      bus.daddr = 32'h600;
      cyc();
      chk("t5_ren", 32'(bus.ramREN), 32'd1);
      adv();
      bus.dREN = 1'b0;
      cyc();
      chk("t5_ren_low", 32'(bus.ramREN), 32'd0);
      chk("t5_dwait", 32'(bus.dwait), 32'd1);
      busy_n = 0;
      bus.iREN  = 1'b1;
      bus.iaddr = 32'h700;
      iq.push_back(32'h700 ^ KEY);
      wait_fire(1'b1, 10, "t5_next_i");
      adv();
      bus.iREN = 1'b0;
      cyc();

      // Reset in the middle of a data grant.
      busy_n = 5;
      bus.dREN  = 1'b1;
      bus.daddr = 32'h800;
      cyc();
      chk("t6_ren", 32'(bus.ramREN), 32'd1);
      nRST = 1'b0;
      cyc();
      check_reset("t6");
      nRST = 1'b1;
      bus.dREN = 1'b0;
      cyc();

      chk("iq_empty", 32'(iq.size()), 32'd0);
      chk("dq_empty", 32'(dq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
